// File: rtl/uart_echo_checker.sv
// Stop-and-wait echo checker: sends a seeded byte ramp to a uart TX port and
// compares each echoed RX byte, reporting pass, mismatch count and timeout.
module uart_echo_checker #(
  parameter int unsigned N_BYTES = 16,
  parameter logic [7:0]  SEED    = 8'h00,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data_in,
  input  logic       uart_rx_ready,
  output logic       uart_rx_read,
  input  logic [7:0] uart_rx_byte,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_count
);

  localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RX,
    S_READ,
    S_CHECK,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rx_read_q, rx_read_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             to_q, to_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       cur_byte;

  // Expected byte for the current index; 8-bit wrap is intended.
  always_comb cur_byte = SEED + 8'(idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rx_read_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    to_d       = to_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          err_d   = '0;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        tx_data_d  = cur_byte;
        tx_start_d = 1'b1;
        tmr_d      = '0;
        state_d    = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        tmr_d = tmr_q + TMR_W'(1);
        // A ready echo takes priority over an expiring timer on the same cycle.
        if (uart_rx_ready) begin
          rx_read_d = 1'b1;
          state_d   = S_READ;
        end else if (tmr_q == TMR_LAST) begin
          to_d    = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if ((uart_rx_byte != cur_byte) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SEND;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = !to_q && (err_q == 8'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rx_read_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      to_q       <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rx_read_q  <= rx_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      to_q       <= to_d;
      err_q      <= err_d;
    end
  end

  assign uart_tx_start   = tx_start_q;
  assign uart_tx_data_in = tx_data_q;
  assign uart_rx_read    = rx_read_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = to_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a delayed loopback model with bit-flip and
// no-echo modes drives a SEED=10 instance; a fast loopback drives a SEED=F8 one.
module tb_uart_echo_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic       tx_start0, tx_start1;
  logic [7:0] tx_data0, tx_data1;
  logic       rx_ready0, rx_ready1;
  logic       rx_read0, rx_read1;
  logic [7:0] rx_byte0 = 8'h00, rx_byte1 = 8'h00;
  logic       busy0, busy1, done0, done1, pass0, pass1, to0, to1;
  logic [7:0] err0, err1;

  always #5 clk = ~clk;

  uart_echo_checker #(.N_BYTES(16), .SEED(8'h10), .TIMEOUT(100)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .uart_tx_start(tx_start0), .uart_tx_data_in(tx_data0),
    .uart_rx_ready(rx_ready0), .uart_rx_read(rx_read0), .uart_rx_byte(rx_byte0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(to0), .err_count(err0)
  );

  uart_echo_checker #(.N_BYTES(16), .SEED(8'hF8), .TIMEOUT(100)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .uart_tx_start(tx_start1), .uart_tx_data_in(tx_data1),
    .uart_rx_ready(rx_ready1), .uart_rx_read(rx_read1), .uart_rx_byte(rx_byte1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(to1), .err_count(err1)
  );

  // Loopback model for u0; control words are written only by the initial block.
  logic        echo_en = 1'b1;
  logic [15:0] flip_mask = 16'h0000;
  int          flush_id = 0, flush_seen = 0;
  int          inj_id = 0, inj_seen = 0;
  logic [7:0]  inj_byte = 8'h00;

  int          cyc = 0, due = 0;
  logic        pend = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic [7:0]  fifo0 [0:7];
  int unsigned wp0 = 0, rp0 = 0;
  logic [7:0]  txlog0 [0:31];
  int          ntx0 = 0, nrd0 = 0, ndone0 = 0, tx_cyc0 = 0, done_cyc0 = 0;

  assign rx_ready0 = (wp0 != rp0);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (flush_id != flush_seen) begin
      flush_seen <= flush_id;
      pend   <= 1'b0;
      wp0    <= 0;
      rp0    <= 0;
      ntx0   <= 0;
      nrd0   <= 0;
      ndone0 <= 0;
    end else begin
      if (inj_id != inj_seen) begin
        inj_seen         <= inj_id;
        fifo0[wp0[2:0]]  <= inj_byte;
        wp0              <= wp0 + 1;
      end else if (pend && cyc >= due) begin
        fifo0[wp0[2:0]]  <= pend_byte;
        wp0              <= wp0 + 1;
        pend             <= 1'b0;
      end
      if (tx_start0) begin
        if (ntx0 < 32) txlog0[ntx0] <= tx_data0;
        ntx0    <= ntx0 + 1;
        tx_cyc0 <= cyc;
        if (echo_en) begin
          pend      <= 1'b1;
          due       <= cyc + 50;
          pend_byte <= tx_data0 ^ {7'b0, flip_mask[ntx0[3:0]]};
        end
      end
      if (rx_read0) begin
        rx_byte0 <= fifo0[rp0[2:0]];
        rp0      <= rp0 + 1;
        nrd0     <= nrd0 + 1;
      end
      if (done0) begin
        ndone0    <= ndone0 + 1;
        done_cyc0 <= cyc;
      end
    end
  end

  // Fast loopback for u1: echo becomes ready a few cycles after each send.
  logic [7:0] txlog1 [0:31];
  int         ntx1 = 0, cnt1 = 0;
  logic       pend1 = 1'b0, rdy1 = 1'b0;
  logic [7:0] hold1 = 8'h00;

  assign rx_ready1 = rdy1;

  always @(negedge clk) begin
    if (tx_start1) begin
      if (ntx1 < 32) txlog1[ntx1] <= tx_data1;
      ntx1  <= ntx1 + 1;
      hold1 <= tx_data1;
      cnt1  <= 3;
      pend1 <= 1'b1;
    end else if (pend1) begin
      if (cnt1 == 0) begin
        rdy1  <= 1'b1;
        pend1 <= 1'b0;
      end else begin
        cnt1 <= cnt1 - 1;
      end
    end
    if (rx_read1) begin
      rx_byte1 <= hold1;
      rdy1     <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush0();
    flush_id = flush_id + 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    @(posedge clk);
    #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && done0) || (which == 1 && done1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic chk_seq0(input string name, input int n);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < n && i < 32; i++) begin
      e = 8'h10 + 8'(i);
      if (txlog0[i] !== e) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        echo;
    logic [15:0] mask;
    logic [7:0]  exp_err;
    logic        exp_pass;
    logic        exp_to;
    int          exp_ntx;
    int          exp_nrd;
  } run_t;

  run_t runs [4];

  initial begin
    runs[0] = '{"clean",   1'b1, 16'h0000, 8'd0,  1'b1, 1'b0, 16, 16};
    runs[1] = '{"flip4_9", 1'b1, 16'h0108, 8'd2,  1'b0, 1'b0, 16, 16};
    runs[2] = '{"noecho",  1'b0, 16'h0000, 8'd0,  1'b0, 1'b1, 1,  0};
    runs[3] = '{"allbad",  1'b1, 16'hFFFF, 8'd16, 1'b0, 1'b0, 16, 16};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0", 32'({tx_start0, tx_data0, rx_read0, busy0, done0, pass0, to0, err0}), 32'd0);
    chk("reset_outs1", 32'({tx_start1, rx_read1, busy1, done1, pass1, to1, err1}), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      echo_en   = runs[r].echo;
      flip_mask = runs[r].mask;
      flush0();
      pulse(0);
      wait_done(0, 3000, {runs[r].name, "_done"});
      repeat (3) @(negedge clk);
      chk({runs[r].name, "_busy"},  32'(busy0), 32'd0);
      chk({runs[r].name, "_pass"},  32'(pass0), 32'(runs[r].exp_pass));
      chk({runs[r].name, "_to"},    32'(to0),   32'(runs[r].exp_to));
      chk({runs[r].name, "_err"},   32'(err0),  32'(runs[r].exp_err));
      chk({runs[r].name, "_ntx"},   32'(ntx0),  32'(runs[r].exp_ntx));
      chk({runs[r].name, "_nrd"},   32'(nrd0),  32'(runs[r].exp_nrd));
      chk({runs[r].name, "_ndone"}, 32'(ndone0), 32'd1);
      chk_seq0({runs[r].name, "_seq"}, ntx0);
      if (!runs[r].echo)
        chk("noecho_latency", 32'((done_cyc0 - tx_cyc0 >= 98) && (done_cyc0 - tx_cyc0 <= 102)), 32'd1);
    end

    // start pulsed mid-run must not restart or extend the run
    echo_en = 1'b1; flip_mask = 16'h0000;
    flush0();
    pulse(0);
    repeat (200) @(negedge clk);
    pulse(0);
    wait_done(0, 3000, "busy_start_done");
    repeat (80) @(negedge clk);
    chk("busy_start_ntx", 32'(ntx0), 32'd16);
    chk("busy_start_pass", 32'(pass0), 32'd1);
    chk("busy_start_ndone", 32'(ndone0), 32'd1);
    chk("busy_start_idle", 32'(busy0), 32'd0);

    // start held high: a second run starts straight after the done pulse
    flush0();
    @(posedge clk); #1 start0 = 1'b1;
    wait_done(0, 3000, "held_done1");
    @(negedge clk);
    chk("held_rerun_busy", 32'(busy0), 32'd1);
    start0 = 1'b0;
    wait_done(0, 3000, "held_done2");
    @(negedge clk);
    chk("held_ndone", 32'(ndone0), 32'd2);
    chk("held_ntx", 32'(ntx0), 32'd32);
    chk("held_pass", 32'(pass0), 32'd1);

    // reset while waiting for the first echo
    flush0();
    pulse(0);
    for (int i = 0; i < 50 && ntx0 == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rst_mid_inwait", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_outs", 32'({tx_start0, tx_data0, rx_read0, busy0, done0, pass0, to0, err0}), 32'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("rst_mid_nodone", 32'(ndone0), 32'd0);
    chk("late_echo_unread", 32'(nrd0), 32'd0);
    chk("late_echo_kept", 32'(rx_ready0), 32'd1);
    flush0();
    pulse(0);
    wait_done(0, 3000, "post_rst_done");
    @(negedge clk);
    chk("post_rst_pass", 32'(pass0), 32'd1);
    chk("post_rst_ntx", 32'(ntx0), 32'd16);
    chk_seq0("post_rst_seq", ntx0);

    // unsolicited byte while idle must stay in the FIFO
    flush0();
    inj_byte = 8'hAA;
    inj_id = inj_id + 1;
    repeat (20) @(negedge clk);
    chk("unsolicited_unread", 32'(nrd0), 32'd0);
    chk("unsolicited_kept", 32'(rx_ready0), 32'd1);
    chk("unsolicited_idle", 32'(busy0), 32'd0);
    flush0();

    // seed near the top of the byte range wraps F8..FF,00..07
    pulse(1);
    wait_done(1, 2000, "wrap_done");
    @(negedge clk);
    chk("wrap_pass", 32'(pass1), 32'd1);
    chk("wrap_err", 32'(err1), 32'd0);
    chk("wrap_to", 32'(to1), 32'd0);
    chk("wrap_ntx", 32'(ntx1), 32'd16);
    begin
      int bad;
      logic [7:0] e;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        e = 8'hF8 + 8'(i);
        if (txlog1[i] !== e) bad++;
      end
      chk("wrap_seq", 32'(bad), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
- Initiator-side counterpart of the UART echo responder.
- Drives a `uart` instance's TX port with a deterministic byte sequence and reads the echoed bytes back from its RX FIFO.
- Compares each returned byte against the sent one and reports pass/fail, mismatch count and timeout.
- Sits in host-emulation or board self-test tops, wired to a uart whose pins loop through the device under test.

Parameters:
- N_BYTES, 16: bytes per run, 1..256.
- SEED, 8'h00: first byte value.
- TIMEOUT, 20000: max clk cycles to wait for each echoed byte; the counter must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- uart_tx_start  out  1  one-cycle pulse to uart, enqueues uart_tx_data_in
- uart_tx_data_in  out  8  byte to transmit
- uart_rx_ready  in  1  uart RX FIFO non-empty
- uart_rx_read  out  1  one-cycle pulse, pops one RX byte
- uart_rx_byte  in  8  popped byte, valid the cycle after uart_rx_read is high
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run (normal or timeout)
- pass  out  1  last run: all bytes matched, no timeout; held until next start
- timeout  out  1  last run aborted on timeout; held until next start
- err_count  out  8  mismatches in last/current run, saturates at 255

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs registered.
- Reset:
  - All outputs 0, state IDLE, index 0, timer 0.
  - rst dominates start and every other event on the same edge.
  - Reset mid-run drops uart_tx_start and uart_rx_read to 0 on that edge.
  - No done pulse is produced by a reset.
- Byte i (0..N_BYTES-1) = (SEED + i) mod 256; 8-bit wrap.
- Stop-and-wait: next byte is sent only after the previous echo is checked; at most one byte is outstanding.
- States:
  - IDLE:
    - start=1 → SEND; busy<=1; pass, timeout, err_count <=0; index<=0.
    - start=0 → stay.
  - SEND:
    - uart_tx_data_in<=byte(index); uart_tx_start<=1 (high exactly one cycle); timer<=0.
    - → WAIT_RX.
  - WAIT_RX:
    - uart_tx_start<=0; timer increments each cycle.
    - uart_rx_ready=1 → uart_rx_read<=1; → READ.
    - Else if timer==TIMEOUT-1 → timeout<=1; → FINISH.
    - rx_ready wins if both occur on the same cycle.
  - READ:
    - uart_rx_read<=0 (exactly one cycle high); → CHECK.
  - CHECK:
    - Sample uart_rx_byte.
    - If ≠ byte(index) → err_count<=sat(err_count+1).
    - If index==N_BYTES-1 → FINISH.
    - Else index<=index+1; → SEND.
  - FINISH:
    - done<=1 for one cycle; busy<=0.
    - pass<= (!timeout && err_count==0), evaluated including the final compare.
    - → IDLE.
- Latency per byte, echo present: SEND→uart_tx_start visible 1 cycle later; from rx_ready sampled high to compare = 2 cycles.
- start while busy: ignored, no effect on the run.
- start held high: a new run starts on the first IDLE cycle after FINISH.
- Unsolicited RX bytes while in IDLE are not read; they stay in the uart FIFO.
- After a timeout, a late echo arriving in IDLE also stays in the FIFO.
- N_BYTES=1: a single SEND/CHECK, then FINISH.
- index width is clog2(N_BYTES) or ≥1 bit.

Test Plan:
- Loopback bench model (echoes each tx byte 50 cycles later, rx_byte valid one cycle after read), SEED=8'h10, N_BYTES=16, start pulse → uart_tx_data_in sequence 0x10..0x1F; done pulses once; pass=1, err_count=0, timeout=0, busy low after done.
- Model flips bit 0 of the 4th and 9th echoes → err_count=2, pass=0, timeout=0.
- SEED=8'hF8, N_BYTES=16 → sent bytes F8..FF then 00..07; all echoed → pass=1.
- Model never echoes, TIMEOUT=100 → exactly one uart_tx_start; done pulses 100 cycles (±2) after it; timeout=1, pass=0, uart_rx_read never asserted.
- Pulse start again while busy, mid-run → no extra uart_tx_start beyond N_BYTES; run completes normally.
- Assert rst for 1 cycle while in WAIT_RX → next cycle all outputs 0, no done pulse; a subsequent start runs a full passing sequence from byte SEED.
